if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
- Holds the PC and drives the instruction-ROM word address.
- Latches {pc, pc+4, inst, valid} into IF/ID for decode.
- Applies load-use stall from the hazard unit and redirect (branch/jump taken) from EX; a flushed slot is a bubble with inst = 32'h0, which decode treats as no instruction.

---
 rtl/if_stage_pkg.sv | 37 +++
 rtl/if_stage_pc_reg.sv | 46 ++++
 rtl/if_stage.sv | 115 +++++++++++
 tb/tb_if_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Constants and types shared by fetch, decode, EX redirect
//               logic and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifid_t;

    // Slot content decode reads as "no instruction".
    localparam ifid_t IFID_BUBBLE = '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(INST_BYTES - 1));
    endfunction

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INST_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
// ============================================================================
// Module      : if_pc_reg
// Description : Fetch PC register with reset/redirect/stall/increment mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Redirect beats stall: the stalled instruction is on the wrong path.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (!stall_i) begin
            pc_d = next_seq_pc(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch plus IF/ID register. Optional performance
//               counters are built when IF_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IROM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IROM_AW-1:0] irom_addr,
    input  logic [31:0]        irom_inst,
    output logic [31:0]        if_pc,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic [31:0]        id_inst,
    output logic               id_valid,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_bubble
);

    logic [31:0] w_pc;
    ifid_t       ifid_q;
    ifid_t       ifid_d;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (w_pc)
    );

    assign if_pc     = w_pc;
    assign irom_addr = w_pc[IROM_AW+1:2];

    always_comb begin
        ifid_d = ifid_q;
        if (redirect) begin
            ifid_d = IFID_BUBBLE;
        end else if (!stall) begin
            ifid_d.pc    = w_pc;
            ifid_d.pc4   = next_seq_pc(w_pc);
            ifid_d.inst  = irom_inst;
            ifid_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q <= IFID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign id_pc    = ifid_q.pc;
    assign id_pc4   = ifid_q.pc4;
    assign id_inst  = ifid_q.inst;
    assign id_valid = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    logic        w_load_fetch;
    logic        w_load_bubble;
    logic [31:0] fetch_q;
    logic [31:0] fetch_d;
    logic [31:0] bubble_q;
    logic [31:0] bubble_d;

    assign w_load_fetch  = !redirect && !stall;
    assign w_load_bubble = redirect;

    always_comb begin
        fetch_d  = fetch_q;
        bubble_d = bubble_q;
        if (w_load_fetch) begin
            fetch_d = fetch_q + 32'd1;
        end
        if (w_load_bubble) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_q  <= 32'h0;
            bubble_q <= 32'h0;
        end else begin
            fetch_q  <= fetch_d;
            bubble_q <= bubble_d;
        end
    end

    assign perf_fetch  = fetch_q;
    assign perf_bubble = bubble_q;
`else
    assign perf_fetch  = 32'h0;
    assign perf_bubble = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam int AW = 14;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] irom_addr;
    logic [31:0]   irom_inst;
    logic [31:0]   if_pc;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc4;
    logic [31:0]   id_inst;
    logic          id_valid;
    logic [31:0]   perf_fetch;
    logic [31:0]   perf_bubble;

    logic [31:0] rom [0:(1<<AW)-1];

    // Reference state: what the spec says IF/ID and the PC hold after each edge.
    logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_fetch, m_bubble;
    logic        m_valid;

    int n_vec;
    int n_err;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IROM_AW  (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irom_addr   (irom_addr),
        .irom_inst   (irom_inst),
        .if_pc       (if_pc),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign irom_inst = rom[irom_addr];

    function automatic logic [31:0] exp_fetch();
`ifdef IF_PERF_CNT_EN
        return m_fetch;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_bubble();
`ifdef IF_PERF_CNT_EN
        return m_bubble;
`else
        return 32'h0;
`endif
    endfunction

    // Apply inputs, advance one edge, update the model, settle before checking.
    task automatic tick(input logic rs, input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] word_idx;
        rst_n = rs; stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        if (!rs) begin
            m_pc = 32'h0; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 0; m_valid = 0;
            m_fetch = 0; m_bubble = 0;
        end else if (rd) begin
            m_pc = rpc / 4 * 4;
            m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 0; m_valid = 0;
            m_bubble = m_bubble + 1;
        end else if (!st) begin
            word_idx  = (m_pc / 4) % (1 << AW);
            m_id_pc   = m_pc;
            m_id_pc4  = m_pc + 4;
            m_id_inst = rom[word_idx];
            m_valid   = 1'b1;
            m_pc      = m_pc + 4;
            m_fetch   = m_fetch + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 32'h0);
        tick(0, 1, 1, 32'h1234);
        n_vec++; if (if_pc !== 32'h0)    begin n_err++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
        n_vec++; if (id_inst !== 32'h0)  begin n_err++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
        n_vec++; if (id_valid !== 1'b0)  begin n_err++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        n_vec++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0)
            begin n_err++; $display("FAIL reset_id_pc got %h/%h want 0/0", id_pc, id_pc4); end
        n_vec++; if (perf_fetch !== 32'h0 || perf_bubble !== 32'h0)
            begin n_err++; $display("FAIL reset_perf got %h/%h want 0/0", perf_fetch, perf_bubble); end
    endtask

    task automatic test_sequential();
        logic [31:0] want_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] want_inst [4] = '{32'h0, 32'h13, 32'h14, 32'h15};
        logic        want_val  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(1, 0, 0, 32'h0);
            n_vec++; if (if_pc !== want_pc[i])
                begin n_err++; $display("FAIL seq_if_pc[%0d] got %h want %h", i, if_pc, want_pc[i]); end
            n_vec++; if (id_inst !== want_inst[i] || id_valid !== want_val[i])
                begin n_err++; $display("FAIL seq_id[%0d] got %h/%b want %h/%b", i, id_inst, id_valid, want_inst[i], want_val[i]); end
            n_vec++; if (i > 0 && id_pc4 !== id_pc + 32'd4)
                begin n_err++; $display("FAIL seq_pc4[%0d] got %h want %h", i, id_pc4, id_pc + 32'd4); end
        end
        tick(1, 0, 0, 32'h0);
    endtask

    task automatic test_stall();
        logic [31:0] f0;
        f0 = perf_fetch;
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 32'h0);
            n_vec++; if (if_pc !== 32'h10 || irom_addr !== AW'(4))
                begin n_err++; $display("FAIL stall_pc[%0d] got %h/%h want 10/4", i, if_pc, irom_addr); end
            n_vec++; if (id_inst !== 32'h16 || id_pc !== 32'hC || id_valid !== 1'b1)
                begin n_err++; $display("FAIL stall_ifid[%0d] got %h/%h/%b want 16/c/1", i, id_inst, id_pc, id_valid); end
            n_vec++; if (perf_fetch !== f0)
                begin n_err++; $display("FAIL stall_perf[%0d] got %h want %h", i, perf_fetch, f0); end
        end
        tick(1, 0, 0, 32'h0);
        n_vec++; if (id_inst !== 32'h17 || id_pc !== 32'h10 || if_pc !== 32'h14)
            begin n_err++; $display("FAIL stall_release got %h/%h/%h want 17/10/14", id_inst, id_pc, if_pc); end
        n_vec++; if (perf_fetch !== exp_fetch())
            begin n_err++; $display("FAIL stall_release_perf got %h want %h", perf_fetch, exp_fetch()); end
    endtask

    task automatic test_redirect();
        logic [31:0] b0;
        b0 = exp_bubble();
        tick(1, 0, 1, 32'h0000_0103);
        n_vec++; if (if_pc !== 32'h100 || id_inst !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0)
            begin n_err++; $display("FAIL redirect got %h/%h/%b/%h want 100/0/0/0", if_pc, id_inst, id_valid, id_pc); end
        n_vec++; if (perf_bubble !== exp_bubble())
            begin n_err++; $display("FAIL redirect_perf got %h want %h (prev %h)", perf_bubble, exp_bubble(), b0); end
        tick(1, 0, 0, 32'h0);
        n_vec++; if (id_pc !== 32'h100 || id_inst !== 32'h53 || id_valid !== 1'b1 || if_pc !== 32'h104)
            begin n_err++; $display("FAIL redirect_target got %h/%h/%b/%h want 100/53/1/104", id_pc, id_inst, id_valid, if_pc); end
    endtask

    task automatic test_redirect_stall();
        tick(1, 1, 1, 32'h0000_0040);
        n_vec++; if (if_pc !== 32'h40 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc4 !== 32'h0)
            begin n_err++; $display("FAIL redir_stall got %h/%b/%h/%h want 40/0/0/0", if_pc, id_valid, id_inst, id_pc4); end
        n_vec++; if (perf_bubble !== exp_bubble())
            begin n_err++; $display("FAIL redir_stall_perf got %h want %h", perf_bubble, exp_bubble()); end
        tick(1, 0, 0, 32'h0);
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 32'h0);
        tick(0, 0, 1, 32'h0000_0200);
        n_vec++; if (if_pc !== 32'h0 || id_pc !== 32'h0 || id_pc4 !== 32'h0 || id_inst !== 32'h0 || id_valid !== 1'b0)
            begin n_err++; $display("FAIL reset_mid got %h/%h/%h/%h/%b want all 0", if_pc, id_pc, id_pc4, id_inst, id_valid); end
        n_vec++; if (perf_fetch !== 32'h0 || perf_bubble !== 32'h0)
            begin n_err++; $display("FAIL reset_mid_perf got %h/%h want 0/0", perf_fetch, perf_bubble); end
        tick(1, 0, 0, 32'h0);
        n_vec++; if (id_inst !== 32'h13 || if_pc !== 32'h4)
            begin n_err++; $display("FAIL reset_mid_first got %h/%h want 13/4", id_inst, if_pc); end
    endtask

    task automatic test_wrap();
        tick(1, 0, 1, 32'hFFFF_FFFE);
        n_vec++; if (if_pc !== 32'hFFFF_FFFC)
            begin n_err++; $display("FAIL wrap_setup got %h want fffffffc", if_pc); end
        tick(1, 0, 0, 32'h0);
        n_vec++; if (if_pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0)
            begin n_err++; $display("FAIL wrap got %h/%h/%h want 0/fffffffc/0", if_pc, id_pc, id_pc4); end
        n_vec++; if (id_inst !== rom[(1<<AW)-1] || id_valid !== 1'b1)
            begin n_err++; $display("FAIL wrap_inst got %h/%b want %h/1", id_inst, id_valid, rom[(1<<AW)-1]); end
    endtask

    task automatic test_random();
        logic rs, st, rd;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 99) >= 3);
            st = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 12);
            tick(rs, st, rd, $urandom);
            n_vec++;
            if (if_pc !== m_pc || irom_addr !== m_pc[AW+1:2] || id_pc !== m_id_pc || id_pc4 !== m_id_pc4 ||
                id_inst !== m_id_inst || id_valid !== m_valid ||
                perf_fetch !== exp_fetch() || perf_bubble !== exp_bubble()) begin
                n_err++;
                $display("FAIL random[%0d] got pc=%h id=%h/%h/%h/%b perf=%h/%h want pc=%h id=%h/%h/%h/%b perf=%h/%h",
                         i, if_pc, id_pc, id_pc4, id_inst, id_valid, perf_fetch, perf_bubble,
                         m_pc, m_id_pc, m_id_pc4, m_id_inst, m_valid, exp_fetch(), exp_bubble());
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m_pc = 0; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 0; m_valid = 0; m_fetch = 0; m_bubble = 0;
        for (int n = 0; n < (1 << AW); n++) begin
            rom[n] = (n < 256) ? 32'h13 + 32'(n) : $urandom;
        end
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
